vec_loader: RTL and testbench
=============================

VEC_LOADER -- requirements
Module: vec_loader

Interface
REQ-001 Parameter Nbits, default 4, element width in bits.
REQ-002 Parameter Ndata, default 4, elements per vector; SHALL be a multiple of Nmac.
REQ-003 Parameter Nmac, default 2, number of parallel MAC lanes downstream.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  element pair offered.
REQ-007 in_ready  output  1  element pair accepted this cycle when in_valid is also high.
REQ-008 in_a  input  Nbits  element of vector A.
REQ-009 in_b  input  Nbits  element of vector B.
REQ-010 in_clear  input  1  synchronous abort; flushes the vector in progress.
REQ-011 A  output  Ndata*Nbits  packed vector A to the MAC array.
REQ-012 B  output  Ndata*Nbits  packed vector B to the MAC array.
REQ-013 mac_clr  output  1  one-cycle pulse clearing the downstream accumulators.
REQ-014 vec_valid  output  1  one-cycle pulse; downstream result is sampleable this cycle.

Function
REQ-015 Localparam LAT = Ndata/Nmac + 1 SHALL set the hold length in cycles.
REQ-016 FSM SHALL have two states: FILL and HOLD.
REQ-017 FILL: in_ready = !in_clear; on handshake, store in_a/in_b at element slot idx (bits [(idx+1)*Nbits-1 : idx*Nbits]); increment idx.
REQ-018 First accepted element after entering FILL SHALL land in slot 0.
REQ-019 Handshake with idx == Ndata-1 SHALL move to HOLD, clear idx to 0 and clear hold_cnt to 0.
REQ-020 HOLD: in_ready = 0; A and B held stable; hold_cnt increments each cycle.
REQ-021 mac_clr = (HOLD && hold_cnt == 0).
REQ-022 vec_valid = (HOLD && hold_cnt == LAT-1); the next state is FILL.
REQ-023 HOLD SHALL last exactly LAT cycles; a new element SHALL NOT be accepted before the cycle after vec_valid.
REQ-024 in_clear in any state SHALL force FILL, idx = 0, hold_cnt = 0, A = B = 0, and suppress mac_clr and vec_valid that cycle.
REQ-025 in_clear takes priority over a simultaneous in_valid; the offered element SHALL be dropped (in_ready low).
REQ-026 Stalls (in_valid low) in FILL SHALL retain idx and partial A/B indefinitely.
REQ-027 The idx counter SHALL be $clog2(Ndata) bits wide (minimum 1) and SHALL never exceed Ndata-1.

Reset
REQ-028 reset SHALL drive state = FILL, idx = 0, hold_cnt = 0, A = 0, B = 0, mac_clr = 0, vec_valid = 0; in_ready = 1 after reset deasserts.
REQ-029 reset asserted mid-FILL or mid-HOLD SHALL discard the partial vector with no vec_valid pulse.

Configuration
REQ-030 Macro VEC_LOADER_ERR_EN SHALL add output err (1 bit).
REQ-031 When VEC_LOADER_ERR_EN is defined, err SHALL set sticky when in_valid is high while in_ready is low and in_clear is low; cleared only by reset or in_clear.
REQ-032 Without VEC_LOADER_ERR_EN, the err port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 The FSM state enum and the LAT derivation function SHALL live in shared package matrix_pkg.
REQ-034 The block SHALL be a single module without sub-modules; A/B slot write-enables SHALL be generated by a generate loop over Ndata.

Verification (Nbits=4, Ndata=4, Nmac=2, LAT=3)
REQ-035 Load a = 1,2,3,4 and b = 1,1,1,1 back-to-back -> A=16'h4321, B=16'h1111; mac_clr 1 cycle after the 4th handshake; vec_valid 3 cycles after it; in_ready low exactly 3 cycles.
REQ-036 Hold in_valid high continuously for 2 vectors -> 4 accepts, 3 stall cycles, 4 accepts; exactly 2 vec_valid pulses.
REQ-037 Pulse in_clear after 2 elements, then load 5,6,7,8 -> A=16'h8765 with no stale slots; vec_valid only after the second load.
REQ-038 Assert in_clear on the same cycle as a 3rd in_valid -> element dropped; idx=0; A=B=0.
REQ-039 Assert reset during the 2nd HOLD cycle -> all outputs 0 immediately; no vec_valid; in_ready=1 after release.
REQ-040 With VEC_LOADER_ERR_EN defined, drive in_valid during HOLD -> err=1 and stays high until in_clear.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the vector loader feeding the MAC array:
// loader FSM state encoding and the derivation of the hold latency.
package matrix_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

    // Cycles the packed vectors stay frozen: one per MAC pass plus one to drain.
    function automatic int calc_lat(input int ndata, input int nmac);
        return ndata / nmac + 1;
    endfunction

endpackage

// File: rtl/vec_loader.sv
// Vector loader: packs streamed element pairs into A/B vectors and holds them for the MAC array.
// Defining VEC_LOADER_ERR_EN adds a sticky `err` output flagging offers made while not ready.
module vec_loader
    import matrix_pkg::*;
#(
    parameter int Nbits = 4,
    parameter int Ndata = 4,
    parameter int Nmac  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Nbits-1:0]       in_a,
    input  logic [Nbits-1:0]       in_b,
    input  logic                   in_clear,
    output logic [Ndata*Nbits-1:0] A,
    output logic [Ndata*Nbits-1:0] B,
    output logic                   mac_clr,
    output logic                   vec_valid
`ifdef VEC_LOADER_ERR_EN
    ,
    output logic                   err
`endif
);

    localparam int LAT   = calc_lat(Ndata, Nmac);
    localparam int IDX_W = (Ndata > 1) ? $clog2(Ndata) : 1;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Ndata - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    loader_state_e          state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [Ndata*Nbits-1:0] a_q, a_d;
    logic [Ndata*Nbits-1:0] b_q, b_d;
    logic [Ndata-1:0]       slot_we;
    logic                   accept;

    assign accept = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < Ndata; gi++) begin : g_slot_we
            assign slot_we[gi] = accept && (idx_q == IDX_W'(gi));
        end
    endgenerate

    // NOTE: A/B are ordinary flops rather than a RAM, so they take the async reset with the rest of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults cover every path, so no latch can be inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        if (in_clear) begin
            state_d    = FILL;
            idx_d      = '0;
            hold_cnt_d = '0;
            a_d        = '0;
            b_d        = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (idx_q == IDX_LAST) begin
                            state_d    = HOLD;
                            idx_d      = '0;
                            hold_cnt_d = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == CNT_LAST) begin
                        state_d    = FILL;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            endcase
            for (int i = 0; i < Ndata; i++) begin
                if (slot_we[i]) begin
                    a_d[i*Nbits +: Nbits] = in_a;
                    b_d[i*Nbits +: Nbits] = in_b;
                end
            end
        end
    end

    // A clear in flight masks the handshake and both downstream pulses.
    always_comb begin
        in_ready  = 1'b0;
        mac_clr   = 1'b0;
        vec_valid = 1'b0;
        if (!in_clear) begin
            in_ready  = (state_q == FILL);
            mac_clr   = (state_q == HOLD) && (hold_cnt_q == '0);
            vec_valid = (state_q == HOLD) && (hold_cnt_q == CNT_LAST);
        end
    end

    assign A = a_q;
    assign B = b_q;

`ifdef VEC_LOADER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (in_clear) begin
            err_d = 1'b0;
        end else if (in_valid && !in_ready) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_vec_loader.sv
// Self-checking bench for vec_loader: directed vectors plus a cycle-level model compared every negedge.
// Build with VEC_LOADER_ERR_EN defined to also cover the sticky err output.
module tb_vec_loader;

    localparam int NBITS = 4;
    localparam int NDATA = 4;
    localparam int NMAC  = 2;
    localparam int LAT   = NDATA / NMAC + 1;
    localparam int VW    = NDATA * NBITS;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic             in_clear;
    logic [VW-1:0]    A;
    logic [VW-1:0]    B;
    logic             mac_clr;
    logic             vec_valid;
`ifdef VEC_LOADER_ERR_EN
    logic             err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vec_loader #(.Nbits(NBITS), .Ndata(NDATA), .Nmac(NMAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clear  (in_clear),
        .A         (A),
        .B         (B),
        .mac_clr   (mac_clr),
        .vec_valid (vec_valid)
`ifdef VEC_LOADER_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elements collected so far and remaining hold cycles (0 = filling).
    logic [NBITS-1:0] m_a [NDATA];
    logic [NBITS-1:0] m_b [NDATA];
    int               m_cnt;
    int               m_hold;
    logic             m_err;

    task automatic model_clear();
        for (int i = 0; i < NDATA; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_cnt  = 0;
        m_hold = 0;
    endtask

    initial begin : monitor
        logic          exp_rdy, exp_mc, exp_vv;
        logic [VW-1:0] exp_A, exp_B;
        model_clear();
        m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_clear();
                m_err = 1'b0;
            end
            exp_rdy = (m_hold == 0) && !in_clear;
            exp_mc  = (m_hold == LAT) && !in_clear;
            exp_vv  = (m_hold == 1) && !in_clear;
            for (int i = 0; i < NDATA; i++) begin
                exp_A[i*NBITS +: NBITS] = m_a[i];
                exp_B[i*NBITS +: NBITS] = m_b[i];
            end
            check("mon_in_ready", in_ready, exp_rdy);
            check("mon_mac_clr", mac_clr, exp_mc);
            check("mon_vec_valid", vec_valid, exp_vv);
            check("mon_A", A, exp_A);
            check("mon_B", B, exp_B);
`ifdef VEC_LOADER_ERR_EN
            check("mon_err", err, m_err);
`endif
            // Advance to what the coming rising edge must produce.
            if (!reset) begin
                if (in_clear) begin
                    model_clear();
                    m_err = 1'b0;
                end else begin
                    if (in_valid && !exp_rdy) m_err = 1'b1;
                    if (m_hold > 0) begin
                        m_hold--;
                    end else if (in_valid) begin
                        m_a[m_cnt] = in_a;
                        m_b[m_cnt] = in_b;
                        m_cnt++;
                        if (m_cnt == NDATA) begin
                            m_cnt  = 0;
                            m_hold = LAT;
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                         input logic c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int n, output int rdy_low, output int vv_cnt, output int mc_cnt,
                           output int vv_at, output int mc_at);
        rdy_low = 0;
        vv_cnt  = 0;
        mc_cnt  = 0;
        vv_at   = -1;
        mc_at   = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!in_ready) rdy_low++;
            if (vec_valid) begin
                vv_cnt++;
                vv_at = i;
            end
            if (mac_clr) begin
                mc_cnt++;
                mc_at = i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rl, vc, mc, va, ma;
        int acc, stall, vv_run, cyc_n;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_clear = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_vec_valid", vec_valid, 0);

        // Back-to-back load of one vector and its hold window.
        for (int i = 0; i < 4; i++) drive(1'b1, NBITS'(i + 1), 4'h1, 1'b0);
        in_valid = 1'b0;
        check("t35_A", A, 16'h4321);
        check("t35_B", B, 16'h1111);
        observe(6, rl, vc, mc, va, ma);
        check("t35_ready_low", rl, 3);
        check("t35_vv_cnt", vc, 1);
        check("t35_vv_at", va, 2);
        check("t35_mc_cnt", mc, 1);
        check("t35_mc_at", ma, 0);

        // in_valid held high across two vectors.
        acc    = 0;
        stall  = 0;
        vv_run = 0;
        cyc_n  = 0;
        while (acc < 8 && cyc_n < 20) begin
            in_valid = 1'b1;
            in_a     = NBITS'(acc + 1);
            in_b     = NBITS'(8 - acc);
            @(negedge clk);
            if (in_ready) acc++;
            else stall++;
            if (vec_valid) vv_run++;
            cyc_n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t36_accepts", acc, 8);
        check("t36_cycles", cyc_n, 11);
        check("t36_stalls", stall, 3);
        check("t36_A", A, 16'h8765);
        check("t36_B", B, 16'h1234);
        observe(4, rl, vc, mc, va, ma);
        check("t36_vv_total", vv_run + vc, 2);

        // Clear after two elements, then a fresh full load.
        drive(1'b1, 4'h9, 4'h9, 1'b0);
        drive(1'b1, 4'hA, 4'hA, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        check("t37_clr_A", A, 0);
        check("t37_clr_B", B, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, NBITS'(i + 5), NBITS'(i + 1), 1'b0);
        in_valid = 1'b0;
        check("t37_A", A, 16'h8765);
        check("t37_B", B, 16'h4321);
        observe(4, rl, vc, mc, va, ma);
        check("t37_vv_cnt", vc, 1);

        // Clear colliding with the third offered element.
        drive(1'b1, 4'h3, 4'h3, 1'b0);
        drive(1'b1, 4'h5, 4'h5, 1'b0);
        in_valid = 1'b1;
        in_a     = 4'h7;
        in_b     = 4'h7;
        in_clear = 1'b1;
        @(negedge clk);
        check("t38_ready_on_clear", in_ready, 0);
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        in_valid = 1'b0;
        check("t38_A", A, 0);
        check("t38_B", B, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, NBITS'(i + 1), NBITS'(i + 5), 1'b0);
        in_valid = 1'b0;
        check("t38_reload_A", A, 16'h4321);
        check("t38_reload_B", B, 16'h8765);
        observe(4, rl, vc, mc, va, ma);

        // Reset during the second hold cycle.
        for (int i = 0; i < 4; i++) drive(1'b1, NBITS'(i + 2), NBITS'(i + 3), 1'b0);
        in_valid = 1'b0;
        check("t39_pre_A", A, 16'h5432);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t39_A", A, 0);
        check("t39_B", B, 0);
        check("t39_mac_clr", mac_clr, 0);
        check("t39_vec_valid", vec_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("t39_ready", in_ready, 1);
        observe(5, rl, vc, mc, va, ma);
        check("t39_vv_cnt", vc, 0);
        check("t39_ready_low", rl, 0);

        // Offers made during HOLD are refused (and flagged when err exists).
        for (int i = 0; i < 4; i++) drive(1'b1, NBITS'(i + 1), NBITS'(i + 1), 1'b0);
        in_valid = 1'b1;
        in_a     = 4'hF;
        in_b     = 4'hF;
        observe(3, rl, vc, mc, va, ma);
        in_valid = 1'b0;
        check("t40_refused", rl, 3);
        check("t40_A", A, 16'h4321);
`ifdef VEC_LOADER_ERR_EN
        check("t40_err_set", err, 1);
`endif
        observe(3, rl, vc, mc, va, ma);
`ifdef VEC_LOADER_ERR_EN
        check("t40_err_sticky", err, 1);
`endif
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        in_clear = 1'b0;
`ifdef VEC_LOADER_ERR_EN
        check("t40_err_cleared", err, 0);
`endif
        check("t40_clr_A", A, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
